ir_bank_store: RTL and testbench
================================

IR_BANK_STORE -- requirements
Module: ir_bank_store

Interface
REQ-001 SHALL have parameter IMPULSE_LENGTH, default 24000, meaning total impulse-response samples (multiple of 8).
REQ-002 SHALL derive localparam SEGMENT = IMPULSE_LENGTH/4, meaning samples per bank.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all ports are listed below:
- audio_clk  input  1  sole clock
- rst_in  input  1  synchronous active-high reset
- load_start  input  1  one-cycle pulse; begins a new IR load
- sample_in  input  16 signed  IR sample or checksum word
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  block accepts sample_in this cycle
- first_ir_index  input  16  even read index within a segment
- second_ir_index  input  16  odd read index (first+1)
- ir_vals  output  8x16 signed  bank-interleaved IR taps
- impulse_in_memory_complete  output  1  IR fully loaded and valid (level)
- load_error  output  1  checksum mismatch on last load (level)
- samples_loaded  output  16  count of IR samples written in current load

Function
REQ-004 SHALL instantiate four dual-port BRAM banks of depth SEGMENT and width 16; port A is write/unused, port B is read.
REQ-005 SHALL implement states IDLE, LOADING, CHECK, LOADED.
REQ-006 load_start in any state SHALL go to LOADING; it SHALL clear samples_loaded, the bank and address counters, impulse_in_memory_complete and load_error.
REQ-007 A sample_valid arriving in the same cycle as load_start SHALL be ignored.
REQ-008 sample_ready SHALL be 1 only in LOADING or CHECK; a transfer occurs when sample_valid and sample_ready are both 1.
REQ-009 Transfer n (0-based) in LOADING SHALL write bank n/SEGMENT at address n mod SEGMENT, using a wrapping address counter plus a bank counter (no divider).
REQ-010 Each LOADING transfer SHALL increment samples_loaded.
REQ-011 After transfer IMPULSE_LENGTH-1, the block SHALL enter CHECK if IR_CHECKSUM_EN is defined, else LOADED, next cycle.
REQ-012 On entering LOADED, impulse_in_memory_complete SHALL assert and remain 1 until reset or load_start.
REQ-013 Read path: ir_vals[2b] SHALL equal bank b at first_ir_index, and ir_vals[2b+1] SHALL equal bank b at second_ir_index, for b = 0..3.
REQ-014 Read latency SHALL be exactly 2 cycles (BRAM read + output register), one new index pair per cycle, fully pipelined.
REQ-015 An index >= SEGMENT SHALL produce 0 on the corresponding taps, with the same 2-cycle latency.
REQ-016 While impulse_in_memory_complete is 0, ir_vals SHALL be 0 (registered gating aligned to the pipeline).
REQ-017 Reads and writes SHALL never target the same bank port; a read during LOADING has no effect on loading.

Reset
REQ-018 When rst_in is high, the block SHALL set state to IDLE and all of the following to 0: sample_ready, ir_vals, impulse_in_memory_complete, load_error, samples_loaded, and all counters and pipeline registers.
REQ-019 Reset mid-load SHALL abandon the load; BRAM contents are not cleared and are not valid until a fresh full load.

Configuration
REQ-020 Macro IR_CHECKSUM_EN: when defined, CHECK SHALL accept one extra transfer holding the checksum.
- Checksum is the mod-2^16 sum of all IMPULSE_LENGTH samples, accumulated during LOADING.
- On a match the block SHALL go to LOADED.
- On a mismatch it SHALL go to IDLE with load_error=1 and complete=0.
REQ-021 Without IR_CHECKSUM_EN, the CHECK state and the accumulator SHALL not exist, and load_error SHALL be constant 0.

Verification
REQ-022 With IMPULSE_LENGTH=32: load_start, then 32 samples of value k+1 with valid held high. Required: samples_loaded=32, complete asserts the cycle after the last transfer (no checksum), and sample_ready=0 thereafter.
REQ-023 After the REQ-022 load, drive first/second = 2/3. Two cycles later ir_vals = {3,4,11,12,19,20,27,28} (taps 0..7).
REQ-024 Toggle sample_valid randomly during a load, and assert valid while in IDLE. Required: only handshaken samples are written, and the IDLE samples are ignored.
REQ-025 Assert rst_in after 10 transfers. Required: all outputs are 0 and state is IDLE; a subsequent full load with new data reads back the new data.
REQ-026 IR_CHECKSUM_EN defined, IMPULSE_LENGTH=32, all samples 0x1000. Checksum 0x0000 gives complete=1. Checksum 0x0001 gives load_error=1, complete=0, and ir_vals stays 0.
REQ-027 load_start in LOADED concurrent with sample_valid. Required: complete drops next cycle, samples_loaded=0, and the concurrent sample is not written.

Source files
------------

// File: rtl/ir_bank_store.sv
// ir_bank_store: four-bank impulse-response store with a streaming load path and an 8-tap interleaved read path.
// Define IR_CHECKSUM_EN to require a trailing mod-2^16 checksum word after each load.
module ir_bank_store #(
    parameter int IMPULSE_LENGTH = 24000
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               load_start,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic [15:0]        first_ir_index,
    input  logic [15:0]        second_ir_index,
    output logic signed [15:0] ir_vals [8],
    output logic               impulse_in_memory_complete,
    output logic               load_error,
    output logic [15:0]        samples_loaded
);
    localparam int SEGMENT = IMPULSE_LENGTH / 4;
    localparam int AW = (SEGMENT > 1) ? $clog2(SEGMENT) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SEGMENT - 1);
    localparam logic [15:0] SEG_LIMIT = 16'(SEGMENT);

`ifdef IR_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOADING, CHECK, LOADED} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOADING, LOADED} state_t;
`endif

    state_t          state, state_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [1:0]      bank, bank_nxt;
    logic [15:0]     count_nxt;
    logic            complete_nxt;
    logic            transfer, write_en, last_sample;

    always_comb begin
        sample_ready = 1'b0;
        if (state == LOADING) sample_ready = 1'b1;
`ifdef IR_CHECKSUM_EN
        if (state == CHECK) sample_ready = 1'b1;
`endif
    end

    // A sample presented alongside load_start belongs to no load and is dropped.
    assign transfer    = sample_valid && sample_ready && !load_start;
    assign write_en    = transfer && (state == LOADING);
    assign last_sample = (bank == 2'd3) && (addr == LAST_ADDR);

`ifdef IR_CHECKSUM_EN
    logic [15:0] checksum;
    logic        error_nxt;
`endif

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        bank_nxt     = bank;
        count_nxt    = samples_loaded;
        complete_nxt = impulse_in_memory_complete;
`ifdef IR_CHECKSUM_EN
        error_nxt    = load_error;
`endif
        if (load_start) begin
            state_nxt    = LOADING;
            addr_nxt     = '0;
            bank_nxt     = '0;
            count_nxt    = '0;
            complete_nxt = 1'b0;
`ifdef IR_CHECKSUM_EN
            error_nxt    = 1'b0;
`endif
        end else if (write_en) begin
            count_nxt = samples_loaded + 16'd1;
            if (addr == LAST_ADDR) begin
                addr_nxt = '0;
                bank_nxt = bank + 2'd1;
            end else begin
                addr_nxt = addr + 1'b1;
            end
            if (last_sample) begin
`ifdef IR_CHECKSUM_EN
                state_nxt = CHECK;
`else
                state_nxt    = LOADED;
                complete_nxt = 1'b1;
`endif
            end
        end
`ifdef IR_CHECKSUM_EN
        else if (transfer && state == CHECK) begin
            if (sample_in == checksum) begin
                state_nxt    = LOADED;
                complete_nxt = 1'b1;
            end else begin
                state_nxt = IDLE;
                error_nxt = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state                      <= IDLE;
            addr                       <= '0;
            bank                       <= '0;
            samples_loaded             <= '0;
            impulse_in_memory_complete <= 1'b0;
        end else begin
            state                      <= state_nxt;
            addr                       <= addr_nxt;
            bank                       <= bank_nxt;
            samples_loaded             <= count_nxt;
            impulse_in_memory_complete <= complete_nxt;
        end
    end

`ifdef IR_CHECKSUM_EN
    always_ff @(posedge audio_clk) begin
        if (rst_in || load_start) begin
            checksum   <= '0;
        end else if (write_en) begin
            checksum   <= checksum + sample_in;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) load_error <= 1'b0;
        else        load_error <= error_nxt;
    end
`else
    assign load_error = 1'b0;
`endif

    logic signed [15:0] mem [4][SEGMENT];
    logic signed [15:0] rd_a [4];
    logic signed [15:0] rd_b [4];
    logic [AW-1:0]      raddr_a, raddr_b;
    logic               in_a, in_b, in_a_q, in_b_q, valid_q;

    assign in_a    = first_ir_index < SEG_LIMIT;
    assign in_b    = second_ir_index < SEG_LIMIT;
    assign raddr_a = in_a ? first_ir_index[AW-1:0] : '0;
    assign raddr_b = in_b ? second_ir_index[AW-1:0] : '0;

    always_ff @(posedge audio_clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (write_en && bank == b[1:0]) mem[b][addr] <= sample_in;
        end
    end

    // Taps need completion both when the bank read was issued and now, so a
    // new load_start blanks the outputs at once and the last write is never read stale.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
            for (int unsigned b = 0; b < 4; b++) begin
                rd_a[b] <= '0;
                rd_b[b] <= '0;
            end
            for (int unsigned i = 0; i < 8; i++) ir_vals[i] <= '0;
        end else begin
            valid_q <= impulse_in_memory_complete;
            in_a_q  <= in_a;
            in_b_q  <= in_b;
            for (int unsigned b = 0; b < 4; b++) begin
                rd_a[b]        <= mem[b][raddr_a];
                rd_b[b]        <= mem[b][raddr_b];
                ir_vals[2*b]   <= (complete_nxt && valid_q && in_a_q) ? rd_a[b] : '0;
                ir_vals[2*b+1] <= (complete_nxt && valid_q && in_b_q) ? rd_b[b] : '0;
            end
        end
    end
endmodule

// File: tb/tb_ir_bank_store.sv
// Self-checking bench for ir_bank_store: a linear-memory reference model checked every cycle,
// plus literal spot checks of reset, load completion and a known read-back pattern.
module tb_ir_bank_store;
    localparam int LEN = 32;
    localparam int SEG = LEN / 4;
`ifdef IR_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic               audio_clk = 1'b0;
    logic               rst_in, load_start, sample_valid, sample_ready;
    logic               complete, load_error;
    logic signed [15:0] sample_in;
    logic [15:0]        first_ir_index, second_ir_index, samples_loaded;
    logic signed [15:0] ir_vals [8];
    int                 errors = 0;
    int                 checks = 0;
    int                 printed = 0;

    ir_bank_store #(.IMPULSE_LENGTH(LEN)) dut (
        .audio_clk                  (audio_clk),
        .rst_in                     (rst_in),
        .load_start                 (load_start),
        .sample_in                  (sample_in),
        .sample_valid               (sample_valid),
        .sample_ready               (sample_ready),
        .first_ir_index             (first_ir_index),
        .second_ir_index            (second_ir_index),
        .ir_vals                    (ir_vals),
        .impulse_in_memory_complete (complete),
        .load_error                 (load_error),
        .samples_loaded             (samples_loaded)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (printed < 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
            printed++;
        end
    endtask

    // Reference model: the impulse response as one linear array; sample n lives in bank n/SEG.
    logic signed [15:0] m_mem [LEN];
    bit                 m_loading, m_checking, m_complete, m_error, m_started;
    int                 m_count;
    logic [15:0]        m_sum;
    logic signed [15:0] exp_taps [8];
    logic signed [15:0] pend [8];
    bit                 pend_ok;

    function automatic logic signed [15:0] lookup(input int b, input logic [15:0] idx);
        if (idx >= SEG) return '0;
        return m_mem[b * SEG + int'(idx)];
    endfunction

    always @(posedge audio_clk) begin
        bit ready, was_complete;
        m_started    = 1'b1;
        ready        = m_loading || m_checking;
        was_complete = m_complete;
        if (rst_in) begin
            m_loading = 0; m_checking = 0; m_complete = 0; m_error = 0;
            m_count = 0; m_sum = '0;
        end else if (load_start) begin
            m_loading = 1; m_checking = 0; m_complete = 0; m_error = 0;
            m_count = 0; m_sum = '0;
        end else if (sample_valid && ready) begin
            if (m_loading) begin
                m_mem[m_count] = sample_in;
                m_sum = m_sum + sample_in;
                m_count++;
                if (m_count == LEN) begin
                    m_loading = 0;
                    if (CSUM) m_checking = 1;
                    else      m_complete = 1;
                end
            end else begin
                m_checking = 0;
                if (sample_in == m_sum) m_complete = 1;
                else                    m_error = 1;
            end
        end
        // A tap shows data read two cycles back only if the IR was complete then and still is.
        for (int i = 0; i < 8; i++) exp_taps[i] = (m_complete && pend_ok) ? pend[i] : '0;
        for (int b = 0; b < 4; b++) begin
            pend[2*b]   = lookup(b, first_ir_index);
            pend[2*b+1] = lookup(b, second_ir_index);
        end
        pend_ok = was_complete && !rst_in;
    end

    always @(negedge audio_clk) begin
        if (m_started) begin
            check("sample_ready", sample_ready, m_loading || m_checking);
            check("complete", complete, m_complete);
            check("load_error", load_error, m_error);
            check("samples_loaded", samples_loaded, m_count);
            for (int i = 0; i < 8; i++) check($sformatf("ir_vals[%0d]", i), ir_vals[i], exp_taps[i]);
        end
    end

    task automatic step();
        @(posedge audio_clk);
        #1;
    endtask

    // pattern 0: k+1, 1: random, 2: 0x1000. abort_after < 0 means run the full load.
    task automatic do_load(input int pattern, input bit rand_valid, input logic [15:0] csum_delta,
                           input int abort_after);
        int n;
        logic [15:0] sum;
        n = 0;
        sum = '0;
        load_start = 1'b1; sample_valid = 1'b1; sample_in = 16'sh7777;
        step();
        load_start = 1'b0;
        check("start_clears_count", samples_loaded, 0);
        check("start_clears_complete", complete, 0);
        while (n < LEN && n != abort_after) begin
            sample_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            case (pattern)
                0:       sample_in = 16'(n + 1);
                1:       sample_in = 16'($urandom);
                default: sample_in = 16'sh1000;
            endcase
            step();
            if (sample_valid) begin
                sum = sum + sample_in;
                n++;
            end
        end
        sample_valid = 1'b0;
        if (CSUM && n == LEN) begin
            sample_valid = 1'b1;
            sample_in = sum + csum_delta;
            step();
            sample_valid = 1'b0;
        end
    endtask

    task automatic random_reads(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 9) == 0) first_ir_index = 16'hFFFE;
            else                           first_ir_index = 16'($urandom_range(0, SEG + 3));
            second_ir_index = first_ir_index + 16'd1;
            sample_valid = 1'($urandom_range(0, 1));
            sample_in = 16'($urandom);
            step();
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; load_start = 1'b0; sample_valid = 1'b0; sample_in = '0;
        first_ir_index = '0; second_ir_index = 16'd1;
        step(); step();
        rst_in = 1'b0;
        check("reset_complete", complete, 0);
        check("reset_count", samples_loaded, 0);
        check("reset_ready", sample_ready, 0);
        check("reset_tap0", ir_vals[0], 0);

        sample_valid = 1'b1; sample_in = 16'sh0055;
        step(); step(); step();
        sample_valid = 1'b0;
        check("idle_valid_ignored", samples_loaded, 0);

        do_load(0, 1'b0, 16'h0000, -1);
        check("load_count", samples_loaded, 32);
        check("load_complete", complete, 1);
        check("load_ready_low", sample_ready, 0);

        first_ir_index = 16'd2; second_ir_index = 16'd3;
        step(); step();
        begin
            int exp_lit [8] = '{3, 4, 11, 12, 19, 20, 27, 28};
            for (int i = 0; i < 8; i++) check($sformatf("readback_tap%0d", i), ir_vals[i], exp_lit[i]);
        end
        random_reads(40);

        do_load(1, 1'b1, 16'h0000, -1);
        check("rand_load_complete", complete, 1);
        random_reads(40);

        do_load(1, 1'b1, 16'h0000, 10);
        check("partial_count", samples_loaded, 10);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("midreset_ready", sample_ready, 0);
        check("midreset_complete", complete, 0);
        check("midreset_count", samples_loaded, 0);
        for (int i = 0; i < 8; i++) check($sformatf("midreset_tap%0d", i), ir_vals[i], 0);
        random_reads(6);
        check("idle_after_reset_count", samples_loaded, 0);

        do_load(1, 1'b0, 16'h0000, -1);
        random_reads(40);

        if (CSUM) begin
            do_load(2, 1'b0, 16'h0000, -1);
            check("csum_ok_complete", complete, 1);
            random_reads(10);
            do_load(2, 1'b0, 16'h0001, -1);
            check("csum_bad_error", load_error, 1);
            check("csum_bad_complete", complete, 0);
            random_reads(10);
            check("csum_bad_tap0", ir_vals[0], 0);
        end

        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
